// File: rtl/timer_service_master.sv
// Avalon-MM master that programs an interval timer, then services each timeout irq and emits a tick.
// Build option TIMER_SERVICE_SNAPSHOT_EN adds the counter snapshot/readback to every service.
module timer_service_master #(
    parameter logic [31:0] PERIOD     = 32'd99999,
    parameter bit          CONTINUOUS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        timer_irq,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    output logic        running,
    output logic        tick_valid,
    output logic [15:0] tick_count,
    output logic [31:0] tick_snapshot,
    output logic        overrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_L, S_CFG_H, S_CFG_C, S_WAIT, S_CLR,
        S_SNAP, S_RDL, S_RDH, S_CAPH, S_EMIT, S_STOP
    } state_t;

    localparam logic [15:0] CTRL_START = {12'b0, 1'b0, 1'b1, CONTINUOUS, 1'b1};
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    state_t      state_q, state_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        running_q, running_d;
    logic        stop_pend_q, stop_pend_d;
    logic        tick_valid_q, tick_valid_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic        overrun_q, overrun_d;
    logic        post_clr;
    logic        in_service;

`ifdef TIMER_SERVICE_SNAPSHOT_EN
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] tick_snapshot_q, tick_snapshot_d;

    assign post_clr = (state_q == S_SNAP) || (state_q == S_RDL) || (state_q == S_RDH) ||
                      (state_q == S_CAPH) || (state_q == S_EMIT);
`else
    logic rdata_unused;

    assign rdata_unused = ^m_readdata;
    assign post_clr     = (state_q == S_EMIT);
`endif

    assign in_service = (state_q == S_CLR) || post_clr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CFG_L;
            S_CFG_L: state_d = S_CFG_H;
            S_CFG_H: state_d = S_CFG_C;
            S_CFG_C: state_d = S_WAIT;
            S_WAIT: begin
                if (stop) begin
                    state_d = S_STOP;
                end else if (timer_irq) begin
                    state_d = S_CLR;
                end
            end
`ifdef TIMER_SERVICE_SNAPSHOT_EN
            S_CLR:   state_d = S_SNAP;
            S_SNAP:  state_d = S_RDL;
            S_RDL:   state_d = S_RDH;
            S_RDH:   state_d = S_CAPH;
            S_CAPH:  state_d = S_EMIT;
`else
            S_CLR:   state_d = S_EMIT;
`endif
            S_EMIT:  state_d = (stop_pend_q || stop) ? S_STOP : S_WAIT;
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being entered
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        case (state_d)
            S_CFG_L: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = PERIOD[15:0];  end
            S_CFG_H: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = PERIOD[31:16]; end
            S_CFG_C: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = CTRL_START;    end
            S_CLR:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
            S_SNAP:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
            S_RDL:   begin cs_d = 1'b1; addr_d = 3'd4; end
            S_RDH:   begin cs_d = 1'b1; addr_d = 3'd5; end
            S_STOP:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = CTRL_STOP;     end
            default: ;
        endcase
    end

    // Status, tick and snapshot datapath
    always_comb begin
        running_d = running_q;
        if (state_q == S_CFG_C) begin
            running_d = 1'b1;
        end else if (state_q == S_STOP) begin
            running_d = 1'b0;
        end

        stop_pend_d = stop_pend_q;
        if (state_q == S_STOP) begin
            stop_pend_d = 1'b0;
        end else if (in_service && stop) begin
            stop_pend_d = 1'b1;
        end

        // irq seen after the clear write landed means a second timeout overlapped this service
        overrun_d = overrun_q;
        if (state_q == S_IDLE && start) begin
            overrun_d = 1'b0;
        end else if (post_clr && timer_irq) begin
            overrun_d = 1'b1;
        end

        tick_valid_d = (state_d == S_EMIT);
        tick_count_d = tick_valid_d ? tick_count_q + 16'd1 : tick_count_q;

`ifdef TIMER_SERVICE_SNAPSHOT_EN
        snap_lo_d       = (state_q == S_RDH) ? m_readdata : snap_lo_q;
        tick_snapshot_d = (state_q == S_CAPH) ? {m_readdata, snap_lo_q} : tick_snapshot_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0000;
            running_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            tick_valid_q <= 1'b0;
            tick_count_q <= 16'h0000;
            overrun_q    <= 1'b0;
        end else begin
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            running_q    <= running_d;
            stop_pend_q  <= stop_pend_d;
            tick_valid_q <= tick_valid_d;
            tick_count_q <= tick_count_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef TIMER_SERVICE_SNAPSHOT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_lo_q       <= 16'h0000;
            tick_snapshot_q <= 32'h0;
        end else begin
            snap_lo_q       <= snap_lo_d;
            tick_snapshot_q <= tick_snapshot_d;
        end
    end

    assign tick_snapshot = tick_snapshot_q;
`else
    assign tick_snapshot = 32'h0;
`endif

    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign running      = running_q;
    assign tick_valid   = tick_valid_q;
    assign tick_count   = tick_count_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_timer_service_master.sv
// Bench for timer_service_master: scripted responder + table vectors + random services,
// and a second instance (PERIOD=9) driving a behavioural interval timer.
module tb_timer_service_master;

`ifdef TIMER_SERVICE_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif
    localparam int LAT     = SNAP_EN ? 6 : 2;
    localparam int RDL_OFF = SNAP_EN ? 3 : 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, timer_irq = 1'b0;
    logic [2:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;
    logic        running, tick_valid, overrun;
    logic [15:0] tick_count;
    logic [31:0] tick_snapshot;
    logic [15:0] snap_lo = 16'h0, snap_hi = 16'h0;

    logic        start9 = 1'b0, stop9 = 1'b0, irq9;
    logic [2:0]  addr9;
    logic        cs9, wn9, running9, tv9, ov9;
    logic [15:0] wd9, rdata9, tc9;
    logic [31:0] ts9;

    int ncmp = 0, nerr = 0;
    int exp_count = 0;
    bit exp_ovr = 1'b0;

    typedef logic [19:0] txn_t;
    txn_t blog[$];
    txn_t exp_q[$];

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        int          stop_off;
        bit          hold;
        logic [31:0] exp_snap;
        bit          exp_run;
    } vec_t;
    vec_t vec[5];

    timer_service_master dut (
        .clk(clk), .reset(rst), .start(start), .stop(stop), .timer_irq(timer_irq),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .running(running),
        .tick_valid(tick_valid), .tick_count(tick_count), .tick_snapshot(tick_snapshot),
        .overrun(overrun)
    );

    timer_service_master #(.PERIOD(32'd9), .CONTINUOUS(1'b1)) dut9 (
        .clk(clk), .reset(rst), .start(start9), .stop(stop9), .timer_irq(irq9),
        .m_address(addr9), .m_chipselect(cs9), .m_write_n(wn9),
        .m_writedata(wd9), .m_readdata(rdata9), .running(running9),
        .tick_valid(tv9), .tick_count(tc9), .tick_snapshot(ts9), .overrun(ov9)
    );

    always #5 clk = ~clk;

    // Scripted responder: read data valid the cycle after the address
    always @(posedge clk)
        m_readdata <= (m_address == 3'd4) ? snap_lo : (m_address == 3'd5) ? snap_hi : 16'h0;

    always @(posedge clk) begin
        #1;
        if (m_chipselect) blog.push_back({~m_write_n, m_address, m_write_n ? 16'h0 : m_writedata});
    end

    // Behavioural interval timer for dut9: counts period+1 clocks per timeout
    logic [15:0] tp_l, tp_h, tsn_l, tsn_h;
    logic [31:0] t_cnt;
    logic        t_run, t_cont, t_ito, t_to;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tp_l <= 0; tp_h <= 0; tsn_l <= 0; tsn_h <= 0; t_cnt <= 0;
            t_run <= 0; t_cont <= 0; t_ito <= 0; t_to <= 0; rdata9 <= 0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to <= 1'b1;
                    t_cnt <= {tp_h, tp_l};
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
            if (cs9 && !wn9) begin
                case (addr9)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito <= wd9[0]; t_cont <= wd9[1];
                        if (wd9[2]) begin t_run <= 1'b1; t_cnt <= {tp_h, tp_l}; end
                        if (wd9[3]) t_run <= 1'b0;
                    end
                    3'd2: tp_l <= wd9;
                    3'd3: tp_h <= wd9;
                    3'd4: {tsn_h, tsn_l} <= t_cnt;
                    default: ;
                endcase
            end
            rdata9 <= (addr9 == 3'd4) ? tsn_l : (addr9 == 3'd5) ? tsn_h : {15'b0, t_to};
        end
    end
    assign irq9 = t_to & t_ito;

    function automatic txn_t wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic txn_t rd(input logic [2:0] a);
        return {1'b0, a, 16'h0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_log(input string nm);
        chk({nm, ":txn_count"}, 32'(blog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < blog.size(); i++)
            chk($sformatf("%s:txn%0d", nm, i), 32'(blog[i]), 32'(exp_q[i]));
    endtask

    // From IDLE: expect the three configuration writes and running after CFG_C
    task automatic do_start(input string nm);
        blog.delete(); exp_q.delete();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, ":running_in_cfgc"}, 32'(running), 32'h0);
        @(negedge clk);
        exp_ovr = 1'b0;
        chk({nm, ":running"}, 32'(running), 32'h1);
        chk({nm, ":overrun_cleared"}, 32'(overrun), 32'h0);
        exp_q.push_back(wr(3'd2, 16'h869F));
        exp_q.push_back(wr(3'd3, 16'h0001));
        exp_q.push_back(wr(3'd1, 16'h0007));
        check_log(nm);
    endtask

    task automatic do_stop(input string nm, input bit with_start);
        blog.delete(); exp_q.delete();
        stop = 1'b1; start = with_start;
        @(negedge clk); stop = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({nm, ":running"}, 32'(running), 32'h0);
        exp_q.push_back(wr(3'd1, 16'h0008));
        check_log(nm);
    endtask

    task automatic ignored_pulse(input string nm, input bit is_start, input bit exp_run);
        blog.delete(); exp_q.delete();
        if (is_start) start = 1'b1; else stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, ":running"}, 32'(running), 32'(exp_run));
        check_log(nm);
    endtask

    // From WAIT: one irq, optional stop at cycle stop_off after sampling (1 = CLR)
    task automatic service(input logic [15:0] lo, input logic [15:0] hi, input int stop_off,
                           input bit hold, input logic [31:0] exp_snap, input bit exp_run,
                           input string nm);
        int lat;
        lat = 0;
        snap_lo = lo; snap_hi = hi;
        blog.delete(); exp_q.delete();
        timer_irq = 1'b1;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (!hold) timer_irq = 1'b0;
            stop = (c == stop_off);
            if (tick_valid) begin
                lat = c;
                timer_irq = 1'b0;
            end
        end
        exp_count = (exp_count + 1) & 32'hFFFF;
        if (hold && SNAP_EN) exp_ovr = 1'b1;
        chk({nm, ":latency"}, 32'(lat), 32'(LAT));
        chk({nm, ":tick_count"}, 32'(tick_count), 32'(exp_count));
        chk({nm, ":tick_snapshot"}, tick_snapshot, exp_snap);
        chk({nm, ":overrun"}, 32'(overrun), 32'(exp_ovr));
        @(negedge clk); stop = 1'b0;
        chk({nm, ":tick_pulse_end"}, 32'(tick_valid), 32'h0);
        @(negedge clk);
        chk({nm, ":running"}, 32'(running), 32'(exp_run));
        exp_q.push_back(wr(3'd0, 16'h0000));
        if (SNAP_EN) begin
            exp_q.push_back(wr(3'd4, 16'h0000));
            exp_q.push_back(rd(3'd4));
            exp_q.push_back(rd(3'd5));
        end
        if (stop_off > 0) exp_q.push_back(wr(3'd1, 16'h0008));
        check_log(nm);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t[3];
        int nt;

        vec[0] = '{16'h1234, 16'hABCD, 0, 1'b1, SNAP_EN ? 32'hABCD1234 : 32'h0, 1'b1};
        vec[1] = '{16'hFFFF, 16'h0000, 0, 1'b0, SNAP_EN ? 32'h0000FFFF : 32'h0, 1'b1};
        vec[2] = '{16'h0000, 16'hFFFF, 0, 1'b0, SNAP_EN ? 32'hFFFF0000 : 32'h0, 1'b1};
        vec[3] = '{16'h5555, 16'hAAAA, RDL_OFF, 1'b0, SNAP_EN ? 32'hAAAA5555 : 32'h0, 1'b0};
        vec[4] = '{16'h0F0F, 16'hF0F0, LAT, 1'b0, SNAP_EN ? 32'hF0F00F0F : 32'h0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst:chipselect", 32'(m_chipselect), 32'h0);
        chk("rst:write_n", 32'(m_write_n), 32'h1);
        chk("rst:address", 32'(m_address), 32'h0);
        chk("rst:writedata", 32'(m_writedata), 32'h0);
        chk("rst:running", 32'(running), 32'h0);
        chk("rst:tick_valid", 32'(tick_valid), 32'h0);
        chk("rst:tick_count", 32'(tick_count), 32'h0);
        chk("rst:tick_snapshot", tick_snapshot, 32'h0);
        chk("rst:overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        ignored_pulse("idle_stop_ignored", 1'b0, 1'b0);
        do_start("cfg");

        for (int i = 0; i < 5; i++) begin
            service(vec[i].lo, vec[i].hi, vec[i].stop_off, vec[i].hold,
                    vec[i].exp_snap, vec[i].exp_run, $sformatf("vec%0d", i));
            if (!vec[i].exp_run) do_start($sformatf("vec%0d_restart", i));
        end

        ignored_pulse("wait_start_ignored", 1'b1, 1'b1);
        do_stop("start_stop_same_cycle", 1'b1);
        do_start("restart1");
        do_stop("wait_stop", 1'b0);
        do_start("restart2");

        // Back-to-back irq: serviced again from the first WAIT cycle after EMIT
        service(16'h1111, 16'h2222, 0, 1'b0, SNAP_EN ? 32'h22221111 : 32'h0, 1'b1, "b2b_a");
        blog.delete();
        service(16'h3333, 16'h4444, 0, 1'b0, SNAP_EN ? 32'h44443333 : 32'h0, 1'b1, "b2b_b");

        force dut.tick_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.tick_count_q;
        exp_count = 32'hFFFF;
        service(16'hBEEF, 16'hDEAD, 0, 1'b0, SNAP_EN ? 32'hDEADBEEF : 32'h0, 1'b1, "wrap");

        // Reset in the middle of a service
        timer_irq = 1'b1;
        @(negedge clk); timer_irq = 1'b0;
        if (SNAP_EN) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst:chipselect", 32'(m_chipselect), 32'h0);
        chk("midrst:running", 32'(running), 32'h0);
        chk("midrst:tick_valid", 32'(tick_valid), 32'h0);
        chk("midrst:tick_count", 32'(tick_count), 32'h0);
        rst = 1'b0;
        exp_count = 0; exp_ovr = 1'b0;
        @(negedge clk);
        do_start("midrst_restart");

        for (int it = 0; it < 30; it++) begin
            int r;
            int so;
            logic [15:0] lo, hi;
            r = $urandom_range(0, 9);
            lo = 16'($urandom);
            hi = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (r < 6) begin
                service(lo, hi, 0, 1'b0, SNAP_EN ? {hi, lo} : 32'h0, 1'b1, "rnd_svc");
            end else if (r < 8) begin
                so = $urandom_range(1, LAT);
                service(lo, hi, so, 1'b0, SNAP_EN ? {hi, lo} : 32'h0, 1'b0, "rnd_svc_stop");
                do_start("rnd_restart");
            end else if (r == 8) begin
                do_stop("rnd_stop", 1'b0);
                do_start("rnd_restart2");
            end else begin
                ignored_pulse("rnd_start_ignored", 1'b1, 1'b1);
            end
        end

        // Real timer, PERIOD=9: a timeout every 10 clocks
        start9 = 1'b1;
        @(negedge clk); start9 = 1'b0;
        nt = 0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        for (int cyc = 0; cyc < 200 && nt < 3; cyc++) begin
            @(negedge clk);
            if (tv9) begin
                t[nt] = cyc;
                chk($sformatf("timer:snapshot%0d", nt), ts9, SNAP_EN ? 32'd7 : 32'd0);
                nt++;
            end
        end
        chk("timer:ticks_seen", 32'(nt), 32'd3);
        chk("timer:interval1", 32'(t[1] - t[0]), 32'd10);
        chk("timer:interval2", 32'(t[2] - t[1]), 32'd10);
        chk("timer:tick_count", 32'(tc9), 32'd3);
        chk("timer:overrun", 32'(ov9), 32'h0);
        chk("timer:running", 32'(running9), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
